vga_frame_sequencer: RTL and testbench

Generates the 640x480@60 raster position (hc, vc), registered sync/blanking strobes, and the ping-pong buffer select (write_to_two) that drives the frame-buffer stage and the VGA DAC pins. The drawing logic requests a buffer swap with a level handshake. The swap is committed only at the start of vertical blanking, so the displayed buffer never changes mid-frame.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_frame_sequencer_mod_counter.sv | 26 ++
 rtl/vga_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_vga_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing defaults and shared types
// for the VGA frame sequencer.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV   = 2;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int HSYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int HSYNC_END   = HSYNC_START + DEF_H_SYNC;
  localparam int VSYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int VSYNC_END   = VSYNC_START + DEF_V_SYNC;

  typedef enum logic {
    IDLE,
    ACK
  } swap_state_t;

endpackage

// File: rtl/vga_frame_sequencer_mod_counter.sv
// Enabled modulo counter; wrap flags the enabled
// cycle in which the count returns to zero.
module mod_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Raster counters, sync decode and ping-pong buffer
// swap committed at the start of vertical blanking.
module vga_frame_sequencer
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       swap_req,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       write_to_two,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HSB = H_VISIBLE + H_FP;
  localparam int HSE = HSB + H_SYNC;
  localparam int VSB = V_VISIBLE + V_FP;
  localparam int VSE = VSB + V_SYNC;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic          div_unused;
  logic          h_wrap;
  logic          v_wrap;

  mod_counter #(.WIDTH(DW), .MODULUS(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (div_cnt),
    .wrap  (div_wrap)
  );

  assign div_unused = ^div_cnt;
  // With CLK_DIV=1 the divider sits on its last value
  // even in reset, so the strobe is gated explicitly.
  assign pix_tick = div_wrap & ~reset;

  mod_counter #(.WIDTH(10), .MODULUS(HT)) u_hc (
    .clk   (clk),
    .reset (reset),
    .en    (pix_tick),
    .count (hc),
    .wrap  (h_wrap)
  );

  mod_counter #(.WIDTH(10), .MODULUS(VT)) u_vc (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (vc),
    .wrap  (v_wrap)
  );

  logic [9:0] hc_n;
  logic [9:0] vc_n;

  always_comb begin
    hc_n = hc;
    vc_n = vc;
    if (h_wrap) begin
      hc_n = '0;
    end else if (pix_tick) begin
      hc_n = hc + 10'd1;
    end
    if (v_wrap) begin
      vc_n = '0;
    end else if (h_wrap) begin
      vc_n = vc + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hsync <= !((hc_n >= 10'(HSB)) && (hc_n < 10'(HSE)));
      vsync <= !((vc_n >= 10'(VSB)) && (vc_n < 10'(VSE)));
      video_on <= (hc_n < 10'(H_VISIBLE))
               && (vc_n < 10'(V_VISIBLE));
      frame_start <= v_wrap;
    end
  end

  swap_state_t state;
  swap_state_t state_n;
  logic        swap_pt;
  logic        take;

  assign swap_pt = h_wrap && (vc == 10'(V_VISIBLE - 1));

  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (swap_pt && swap_req) begin
          state_n = ACK;
          take    = 1'b1;
        end
      end
      ACK: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      write_to_two <= 1'b0;
      frame_count  <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        write_to_two <= ~write_to_two;
        frame_count  <= frame_count + 8'd1;
      end
    end
  end

  assign swap_ack = (state == ACK);

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for vga_frame_sequencer: reference raster model,
// swap scoreboard, and a CLK_DIV=1 wrap run.
module tb_vga_frame_sequencer;

  localparam int CD = 2;
  localparam int HV = 16, HF = 2, HS = 4, HB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 8, VF = 2, VS = 2, VB = 3;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_A = HT * VT * CD;

  localparam int BHV = 8, BHF = 1, BHS = 2, BHB = 1;
  localparam int BVV = 4, BVF = 1, BVS = 1, BVB = 1;
  localparam int FRAME_B =
    (BHV + BHF + BHS + BHB) * (BVV + BVF + BVS + BVB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, req_a;
  logic [9:0] hc_a, vc_a;
  logic       hs_a, vs_a, von_a, pt_a;
  logic       w2_a, ack_a, fs_a;
  logic [7:0] fc_a;

  logic       rst_b, req_b;
  logic [9:0] hc_b, vc_b;
  logic       hs_b, vs_b, von_b, pt_b;
  logic       w2_b, ack_b, fs_b;
  logic [7:0] fc_b;

  vga_frame_sequencer #(
    .CLK_DIV(CD),
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_a (
    .clk(clk), .reset(rst_a), .swap_req(req_a),
    .hc(hc_a), .vc(vc_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .pix_tick(pt_a),
    .write_to_two(w2_a), .swap_ack(ack_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_frame_sequencer #(
    .CLK_DIV(1),
    .H_VISIBLE(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_VISIBLE(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
  ) u_b (
    .clk(clk), .reset(rst_b), .swap_req(req_b),
    .hc(hc_b), .vc(vc_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .pix_tick(pt_b),
    .write_to_two(w2_b), .swap_ack(ack_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int   m_tick, m_hc, m_vc, m_fc;
  bit   m_w2, m_ack, m_fs;
  logic [8:0] sb[$];

  task automatic model_reset();
    m_tick = 0; m_hc = 0; m_vc = 0; m_fc = 0;
    m_w2 = 0; m_ack = 0; m_fs = 0;
  endtask

  task automatic model_step();
    if (rst_a) begin
      model_reset();
    end else begin
      m_ack = 0;
      m_fs  = 0;
      if (m_tick == CD - 1) begin
        m_tick = 0;
        if (m_hc == HT - 1 && m_vc == VV - 1 && req_a) begin
          m_w2  = !m_w2;
          m_fc  = (m_fc + 1) % 256;
          m_ack = 1;
          sb.push_back({m_w2, 8'(m_fc)});
        end
        if (m_hc == HT - 1) begin
          m_hc = 0;
          m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
          if (m_vc == 0) m_fs = 1;
        end else begin
          m_hc++;
        end
      end else begin
        m_tick++;
      end
    end
  endtask

  task automatic compare_a();
    logic [8:0] e;
    check("hc", hc_a, m_hc);
    check("vc", vc_a, m_vc);
    check("hsync", hs_a,
          !(m_hc >= HV + HF && m_hc < HV + HF + HS));
    check("vsync", vs_a,
          !(m_vc >= VV + VF && m_vc < VV + VF + VS));
    check("video_on", von_a, m_hc < HV && m_vc < VV);
    check("pix_tick", pt_a, !rst_a && m_tick == CD - 1);
    check("frame_start", fs_a, m_fs);
    check("swap_ack", ack_a, m_ack);
    check("write_to_two", w2_a, m_w2);
    check("frame_count", fc_a, m_fc);
    if (ack_a === 1'b1) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_w2", w2_a, e[8]);
        check("sb_fc", fc_a, e[7:0]);
      end
    end
  endtask

  task automatic cyc_a();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_a();
  endtask

  initial begin
    int n, cnt, first, voff, fsn, acks, bad_tick;
    rst_a = 1; req_a = 0;
    rst_b = 1; req_b = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_a();

    rst_a = 0;
    for (n = 0; n < 8; n++) begin
      if (hc_a == 10'd1) break;
      cyc_a();
    end
    check("first_advance_edges", n, CD);

    for (n = 0; n < 2 * FRAME_A; n++) begin
      if (m_hc == 13 && m_vc == 5) break;
      cyc_a();
    end
    check("reach_mid_line", n < 2 * FRAME_A, 1);
    rst_a = 1;
    model_reset();
    #1;
    compare_a();
    cyc_a();
    rst_a = 0;

    for (n = 0; n < 2 * FRAME_A; n++) begin
      if (m_vc == 1 && m_hc == 0 && m_tick == 0) break;
      cyc_a();
    end
    check("reach_line1", n < 2 * FRAME_A, 1);
    cnt = 0; first = -1; voff = 0;
    for (int i = 0; i < HT * CD; i++) begin
      cyc_a();
      if (pt_a) begin
        if (!hs_a) begin
          cnt++;
          if (first < 0) first = int'(hc_a);
        end
        if (!von_a) voff++;
      end
    end
    check("hsync_low_ticks", cnt, HS);
    check("hsync_first_hc", first, HV + HF);
    check("video_off_ticks", voff, HT - HV);

    cnt = 0; fsn = 0;
    for (int i = 0; i < FRAME_A; i++) begin
      cyc_a();
      if (pt_a && !vs_a) cnt++;
      if (fs_a) begin
        fsn++;
        check("fs_origin", {hc_a, vc_a}, 0);
      end
    end
    check("vsync_low_ticks", cnt, VS * HT);
    check("frame_start_per_frame", fsn, 1);

    for (n = 0; n < 2 * FRAME_A; n++) begin
      if (m_vc == 5 && m_hc == 0) break;
      cyc_a();
    end
    req_a = 1;
    for (n = 0; n < 2 * FRAME_A; n++) begin
      cyc_a();
      if (ack_a) break;
    end
    check("swap_taken", n < 2 * FRAME_A, 1);
    check("swap_w2", w2_a, 1);
    check("swap_fc", fc_a, 1);
    req_a = 0;

    acks = 0;
    for (int i = 0; i < FRAME_A; i++) begin
      cyc_a();
      if (ack_a) acks++;
    end
    check("skip_no_ack", acks, 0);
    check("skip_w2", w2_a, 1);

    for (n = 0; n < 2 * FRAME_A; n++) begin
      if (m_vc == VV + 1) break;
      cyc_a();
    end
    req_a = 1;
    for (n = 0; n < 2 * FRAME_A; n++) begin
      cyc_a();
      if (ack_a) break;
    end
    check("late_ack_seen", n < 2 * FRAME_A, 1);
    check("late_wait", n > FRAME_A / 2, 1);
    check("late_ack_vc", vc_a, VV);
    check("late_ack_hc", hc_a, 0);
    check("late_w2", w2_a, 0);

    acks = 0;
    for (int i = 0; i < FRAME_A + 4; i++) begin
      cyc_a();
      if (ack_a) acks++;
    end
    check("held_second_swap", acks, 1);
    check("held_fc", fc_a, 3);

    for (n = 0; n < 2 * FRAME_A; n++) begin
      cyc_a();
      if (ack_a) break;
    end
    check("ack_before_reset", ack_a, 1);
    rst_a = 1;
    req_a = 0;
    model_reset();
    #1;
    compare_a();
    check("reset_drops_ack", ack_a, 0);
    cyc_a();
    check("sb_empty", sb.size(), 0);

    #1;
    check("b_reset_tick", pt_b, 0);
    check("b_reset_fc", fc_b, 0);
    rst_b = 0;
    #1;
    check("b_tick_after_reset", pt_b, 1);
    req_b = 1;
    acks = 0; bad_tick = 0;
    for (n = 0; n < 260 * FRAME_B; n++) begin
      @(negedge clk);
      if (pt_b !== 1'b1) bad_tick++;
      if (ack_b) begin
        acks++;
        check("b_fc", fc_b, acks % 256);
        if (acks == 3) begin
          check("b_three_fc", fc_b, 3);
          check("b_three_w2", w2_b, 1);
        end
        if (acks == 256) break;
      end
    end
    check("b_acks", acks, 256);
    check("b_wrap_fc", fc_b, 0);
    check("b_wrap_w2", w2_b, 0);
    check("b_tick_const", bad_tick, 0);
    req_b = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
